// File: rtl/ddr3_write_queue_if.sv
// Producer-side request handshake plus writer-side strobe/completion signals
// of the DDR3 write queue.
interface ddr3_write_queue_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_addr;
    logic [31:0]   in_data;
    logic          test_wr;
    logic [31:0]   test_addr;
    logic [31:0]   test_wr_data;
    logic          wr_finish;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          timeout_err;

    modport master (
        output in_valid, in_addr, in_data, wr_finish,
        input  in_ready, test_wr, test_addr, test_wr_data, fifo_count, busy, timeout_err
    );

    modport slave (
        input  in_valid, in_addr, in_data, wr_finish,
        output in_ready, test_wr, test_addr, test_wr_data, fifo_count, busy, timeout_err
    );
endinterface

// File: rtl/ddr3_write_queue.sv
// Request FIFO in front of the DDR3 single-word writer: issues one write at a time and
// waits for wr_finish, with a completion timeout that raises a sticky error.
module ddr3_write_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic               ddr3_clk,
    input logic               reset_n,
    ddr3_write_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e        state_q, state_d;
    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic          test_wr_q, test_wr_d;
    logic [31:0]   addr_q, addr_d, data_q, data_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          tmo_hit;

    assign bus.in_ready     = (count_q < CW'(DEPTH));
    assign push             = bus.in_valid && bus.in_ready;
    assign pop              = (state_q == StIdle) && (count_q != '0);
    assign count_d          = count_q + CW'(push) - CW'(pop);
    assign tmo_hit          = (tmo_q == 16'(TIMEOUT - 1));

    assign bus.test_wr      = test_wr_q;
    assign bus.test_addr    = addr_q;
    assign bus.test_wr_data = data_q;
    assign bus.fifo_count   = count_q;
    assign bus.timeout_err  = err_q;
    assign bus.busy         = (state_q != StIdle) || (count_q != '0);

    always_ff @(posedge ddr3_clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (count_q != '0) state_d = StIssue;
            StIssue:    state_d = StWaitDone;
            // wr_finish takes priority over a coinciding timeout expiry
            StWaitDone: if (bus.wr_finish || tmo_hit) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        test_wr_d = pop;
        addr_d    = pop ? mem_q[rd_ptr_q][63:32] : addr_q;
        data_d    = pop ? mem_q[rd_ptr_q][31:0]  : data_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        unique case (state_q)
            StIssue:    tmo_d = '0;
            StWaitDone: begin
                tmo_d = tmo_q + 16'd1;
                if (!bus.wr_finish && tmo_hit) err_d = 1'b1;
            end
            default:    ;
        endcase
    end

    always_ff @(posedge ddr3_clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            test_wr_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q   <= count_d;
            test_wr_q <= test_wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge ddr3_clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_addr, bus.in_data};
    end
endmodule

// File: tb/tb_ddr3_write_queue.sv
// Directed bench for ddr3_write_queue: one DUT with a long timeout for queue/order tests,
// one with TIMEOUT=8 for the timeout scenarios.
module tb_ddr3_write_queue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ddr3_write_queue_if #(.DEPTH(16)) bus ();
    ddr3_write_queue_if #(.DEPTH(16)) bus_t ();

    ddr3_write_queue #(.DEPTH(16), .TIMEOUT(64)) u_dut (
        .ddr3_clk (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    ddr3_write_queue #(.DEPTH(16), .TIMEOUT(8)) u_dut_t (
        .ddr3_clk (clk),
        .reset_n  (reset_n),
        .bus      (bus_t.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic        auto_fin = 1'b0;
    logic        man_fin = 1'b0;
    int          auto_lat = 0;
    int          fin_cnt = 0;
    logic        prev_wr = 1'b0;
    logic        dbl_wr = 1'b0;
    logic [63:0] issued [$];

    assign bus.wr_finish = auto_fin | man_fin;

    // Writer model: records every strobe and optionally answers after auto_lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            auto_fin = 1'b0;
            if (bus.test_wr) begin
                if (prev_wr) dbl_wr = 1'b1;
                issued.push_back({bus.test_addr, bus.test_wr_data});
                if (auto_lat > 0) fin_cnt = auto_lat;
            end else if (fin_cnt > 0) begin
                fin_cnt--;
                if (fin_cnt == 0) auto_fin = 1'b1;
            end
            prev_wr = bus.test_wr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        man_fin        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_addr    = '0;
        bus.in_data    = '0;
        bus_t.in_valid = 1'b0;
        bus_t.in_addr  = '0;
        bus_t.in_data  = '0;
        bus_t.wr_finish = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.in_ready, bus.test_wr, bus.busy, bus.timeout_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got rdy/wr/busy/err=%b required 1000",
                     {bus.in_ready, bus.test_wr, bus.busy, bus.timeout_err});
        end
        checks++;
        if (bus.fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", bus.fifo_count);
        end
        checks++;
        if ({bus.test_addr, bus.test_wr_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_addr_data: got %h required 0", {bus.test_addr, bus.test_wr_data});
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h10;
        bus.in_data  = 32'hDEAD_BEEF;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.test_wr, bus.fifo_count} !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL single_queued: got wr=%b count=%0d required wr=0 count=1",
                     bus.test_wr, bus.fifo_count);
        end
        tick();
        checks++;
        if ({bus.test_wr, bus.test_addr, bus.test_wr_data, bus.fifo_count} !==
            {1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0}) begin
            errors++;
            $display("FAIL single_issue: got wr=%b addr=%h data=%h count=%0d required 1 10 deadbeef 0",
                     bus.test_wr, bus.test_addr, bus.test_wr_data, bus.fifo_count);
        end
        tick();
        checks++;
        if ({bus.test_wr, bus.test_addr, bus.busy} !== {1'b0, 32'h10, 1'b1}) begin
            errors++;
            $display("FAIL single_pulse_width: got wr=%b addr=%h busy=%b required 0 10 1",
                     bus.test_wr, bus.test_addr, bus.busy);
        end
        repeat (3) tick();
        man_fin = 1'b1;
        tick();
        man_fin = 1'b0;
        checks++;
        if ({bus.busy, bus.timeout_err} !== 2'b00) begin
            errors++;
            $display("FAIL single_done: got busy=%b err=%b required 0 0", bus.busy, bus.timeout_err);
        end
    endtask

    task automatic test_fill();
        do_reset();
        issued.delete();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_addr = 32'h100 + 32'(i) * 4;
            bus.in_data = 32'hA000_0000 + 32'(i);
            tick();
            if (i == 15) begin
                checks++;
                if ({bus.fifo_count, bus.in_ready} !== {5'd15, 1'b1}) begin
                    errors++;
                    $display("FAIL fill_count15: got count=%0d rdy=%b required 15 1",
                             bus.fifo_count, bus.in_ready);
                end
            end
        end
        checks++;
        if ({bus.fifo_count, bus.in_ready} !== {5'd16, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: got count=%0d rdy=%b required 16 0", bus.fifo_count, bus.in_ready);
        end
        bus.in_addr = 32'hBAD;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL fill_push_when_full: got count=%0d required 16", bus.fifo_count);
        end
        man_fin = 1'b1;
        tick();
        man_fin = 1'b0;
        auto_lat = 2;
        tick();
        checks++;
        if ({bus.fifo_count, bus.in_ready, bus.test_wr, bus.test_addr} !==
            {5'd15, 1'b1, 1'b1, 32'h104}) begin
            errors++;
            $display("FAIL fill_first_pop: got count=%0d rdy=%b wr=%b addr=%h required 15 1 1 104",
                     bus.fifo_count, bus.in_ready, bus.test_wr, bus.test_addr);
        end
        for (int c = 0; c < 400 && bus.busy; c++) tick();
        auto_lat = 0;
        checks++;
        if (issued.size() !== 17) begin
            errors++;
            $display("FAIL fill_issue_count: got %0d required 17", issued.size());
        end
        for (int i = 0; i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== {32'h100 + 32'(i) * 4, 32'hA000_0000 + 32'(i)}) begin
                errors++;
                $display("FAIL fill_order[%0d]: got %h required %h", i, issued[i],
                         {32'h100 + 32'(i) * 4, 32'hA000_0000 + 32'(i)});
            end
        end
    endtask

    task automatic test_stream();
        int   idx;
        logic rdy;
        do_reset();
        issued.delete();
        auto_lat     = 3;
        idx          = 0;
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h0300_0000;
        bus.in_data  = 32'h5A5A_0000;
        for (int c = 0; c < 3000 && idx < 40; c++) begin
            rdy = bus.in_ready;
            tick();
            if (rdy) begin
                idx++;
                bus.in_addr = 32'h0300_0000 + 32'(idx);
                bus.in_data = 32'h5A5A_0000 + 32'(idx);
            end
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 600 && bus.busy; c++) tick();
        auto_lat = 0;
        checks++;
        if ({issued.size(), bus.busy} !== {32'd40, 1'b0}) begin
            errors++;
            $display("FAIL stream_count: got issued=%0d busy=%b required 40 0", issued.size(), bus.busy);
        end
        for (int i = 0; i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== {32'h0300_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)}) begin
                errors++;
                $display("FAIL stream_order[%0d]: got %h required %h", i, issued[i],
                         {32'h0300_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)});
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus_t.in_valid = 1'b1;
        bus_t.in_addr  = 32'h40;
        bus_t.in_data  = 32'h1111_1111;
        tick();
        bus_t.in_addr  = 32'h44;
        bus_t.in_data  = 32'h2222_2222;
        tick();
        bus_t.in_valid = 1'b0;
        checks++;
        if ({bus_t.test_wr, bus_t.test_addr, bus_t.fifo_count} !== {1'b1, 32'h40, 5'd1}) begin
            errors++;
            $display("FAIL tmo_first_issue: got wr=%b addr=%h count=%0d required 1 40 1",
                     bus_t.test_wr, bus_t.test_addr, bus_t.fifo_count);
        end
        tick();
        repeat (7) tick();
        checks++;
        if ({bus_t.timeout_err, bus_t.test_wr} !== 2'b00) begin
            errors++;
            $display("FAIL tmo_early: got err=%b wr=%b after 7 wait cycles required 0 0",
                     bus_t.timeout_err, bus_t.test_wr);
        end
        tick();
        checks++;
        if (bus_t.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_expire: got err=%b after 8 wait cycles required 1", bus_t.timeout_err);
        end
        tick();
        checks++;
        if ({bus_t.test_wr, bus_t.test_addr, bus_t.test_wr_data, bus_t.timeout_err} !==
            {1'b1, 32'h44, 32'h2222_2222, 1'b1}) begin
            errors++;
            $display("FAIL tmo_next_issue: got wr=%b addr=%h data=%h err=%b required 1 44 22222222 1",
                     bus_t.test_wr, bus_t.test_addr, bus_t.test_wr_data, bus_t.timeout_err);
        end
        tick();
        bus_t.wr_finish = 1'b1;
        tick();
        bus_t.wr_finish = 1'b0;
        checks++;
        if ({bus_t.timeout_err, bus_t.busy} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_sticky: got err=%b busy=%b required 1 0", bus_t.timeout_err, bus_t.busy);
        end
    endtask

    task automatic test_race();
        do_reset();
        bus_t.in_valid = 1'b1;
        bus_t.in_addr  = 32'h80;
        bus_t.in_data  = 32'h3333_3333;
        tick();
        bus_t.in_valid = 1'b0;
        repeat (2) tick();
        repeat (7) tick();
        bus_t.wr_finish = 1'b1;
        tick();
        bus_t.wr_finish = 1'b0;
        checks++;
        if ({bus_t.timeout_err, bus_t.busy} !== 2'b00) begin
            errors++;
            $display("FAIL race_finish_wins: got err=%b busy=%b required 0 0",
                     bus_t.timeout_err, bus_t.busy);
        end
        bus_t.wr_finish = 1'b1;
        tick();
        bus_t.wr_finish = 1'b0;
        checks++;
        if ({bus_t.timeout_err, bus_t.busy, bus_t.test_wr} !== 3'b000) begin
            errors++;
            $display("FAIL race_idle_finish: got err=%b busy=%b wr=%b required 000",
                     bus_t.timeout_err, bus_t.busy, bus_t.test_wr);
        end
        bus_t.in_valid = 1'b1;
        bus_t.in_addr  = 32'h84;
        tick();
        bus_t.in_valid = 1'b0;
        tick();
        bus_t.wr_finish = 1'b1;
        tick();
        bus_t.wr_finish = 1'b0;
        tick();
        checks++;
        if ({bus_t.busy, bus_t.test_addr} !== {1'b1, 32'h84}) begin
            errors++;
            $display("FAIL race_issue_finish_ignored: got busy=%b addr=%h required 1 84",
                     bus_t.busy, bus_t.test_addr);
        end
        bus_t.wr_finish = 1'b1;
        tick();
        bus_t.wr_finish = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_addr = 32'h700 + 32'(i);
            bus.in_data = 32'hB0 + 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.fifo_count, bus.busy} !== {5'd5, 1'b1}) begin
            errors++;
            $display("FAIL rmid_before: got count=%0d busy=%b required 5 1", bus.fifo_count, bus.busy);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if ({bus.fifo_count, bus.test_wr, bus.test_addr, bus.test_wr_data, bus.timeout_err, bus.busy} !==
            {5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_after: got count=%0d wr=%b addr=%h data=%h err=%b busy=%b required all 0",
                     bus.fifo_count, bus.test_wr, bus.test_addr, bus.test_wr_data, bus.timeout_err,
                     bus.busy);
        end
        n0 = issued.size();
        repeat (6) tick();
        checks++;
        if ({issued.size(), bus.busy} !== {n0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_no_issue: got issued=%0d busy=%b required %0d 0", issued.size(), bus.busy, n0);
        end
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h7777_0000;
        bus.in_data  = 32'hCAFE;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if ({bus.test_wr, bus.test_addr, bus.test_wr_data} !== {1'b1, 32'h7777_0000, 32'hCAFE}) begin
            errors++;
            $display("FAIL rmid_new_issue: got wr=%b addr=%h data=%h required 1 77770000 cafe",
                     bus.test_wr, bus.test_addr, bus.test_wr_data);
        end
        tick();
        man_fin = 1'b1;
        tick();
        man_fin = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_timeout();
        test_race();
        test_reset_mid();
        checks++;
        if (dbl_wr !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse_width: got consecutive test_wr=%b required 0", dbl_wr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
